// File: rtl/lut_loader_pkg.sv
// rtl/lut_loader_pkg.sv - shared types and constants for the LUT stream loader
package lut_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CSUM = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CSUM_WIDTH        = 8;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/lut_word_assembler.sv
// rtl/lut_word_assembler.sv - MSB-first byte-to-word shifter with registered word-ready strobe
module lut_word_assembler
    import lut_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  last_byte,
    output logic                  word_ready
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);

    logic [2:0] cnt;

    assign last_byte = (cnt == 3'(BPW - 1));

    // word_ready lands one cycle after the final byte, when word already holds it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= in_valid && last_byte;
            if (clr) begin
                cnt <= '0;
            end else if (in_valid) begin
                cnt  <= last_byte ? 3'd0 : cnt + 3'd1;
                word <= (word << 8) | DATA_WIDTH'(in_data);
            end
        end
    end

endmodule

// File: rtl/lut_stream_loader.sv
// rtl/lut_stream_loader.sv - framed byte-stream writer for single-port lookup-table RAMs
module lut_stream_loader
    import lut_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT    = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic [ADDR_WIDTH-1:0] lkp_addr,
    output logic [DATA_WIDTH-1:0] lkp_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  busy,
    output logic                  tbl_valid,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [CSUM_WIDTH-1:0] sum, sum_chk;
    logic [TW-1:0]         tcnt;
    logic                  tbl_valid_d;
    logic                  accept, in_frame, tout_hit, sync_seen, byte_recv, csum_take, table_end;
    logic                  last_byte, word_ready;
    logic                  done_nx, err_nx, tbl_valid_nx;

    assign accept    = s_valid && s_ready;
    assign in_frame  = (state != IDLE);
    assign sync_seen = (state == IDLE) && accept && (s_data == SYNC_BYTE);
    assign byte_recv = (state == RECV) && accept;
    assign csum_take = (state == CSUM) && accept;
    // An accepted byte beats an expiring counter on the same cycle
    assign tout_hit  = in_frame && !accept && (tcnt == TW'(TIMEOUT - 1));
    // Leave RECV on the final byte so a back-to-back checksum byte is never taken as data
    assign table_end = byte_recv && last_byte && (waddr == '1);
    assign sum_chk   = sum + s_data;

    lut_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (sync_seen),
        .in_valid   (byte_recv),
        .in_data    (s_data),
        .word       (ram_wr_data),
        .last_byte  (last_byte),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sync_seen) state_nx = RECV;
            RECV:    if (table_end) state_nx = CSUM;
                     else if (tout_hit) state_nx = IDLE;
            CSUM:    if (csum_take || tout_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done_nx      = csum_take && (sum_chk == '0);
        err_nx       = (csum_take && (sum_chk != '0)) || tout_hit;
        tbl_valid_nx = tbl_valid;
        if (sync_seen) tbl_valid_nx = 1'b0;
        else if (done_nx) tbl_valid_nx = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            tbl_valid   <= 1'b1;
            tbl_valid_d <= 1'b1;
            waddr       <= '0;
            sum         <= '0;
            tcnt        <= '0;
        end else begin
            s_ready     <= 1'b1;
            busy        <= (state_nx != IDLE);
            load_done   <= done_nx;
            load_err    <= err_nx;
            tbl_valid   <= tbl_valid_nx;
            tbl_valid_d <= tbl_valid;
            if (sync_seen) begin
                waddr <= '0;
                sum   <= '0;
            end else begin
                if (word_ready) waddr <= waddr + 1'b1;
                if (byte_recv)  sum   <= sum_chk;
            end
            if (!in_frame || accept) tcnt <= '0;
            else                     tcnt <= tcnt + 1'b1;
        end
    end

    assign ram_addr  = busy ? waddr : lkp_addr;
    assign ram_wr_en = word_ready && busy;
    assign lkp_data  = tbl_valid_d ? ram_rd_data : '0;

endmodule

// File: tb/tb_lut_stream_loader.sv
// tb/tb_lut_stream_loader.sv - self-checking bench for lut_stream_loader
module tb_lut_stream_loader;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n, s_valid, s_ready;
    logic [7:0]    s_data;
    logic [AW-1:0] lkp_addr, ram_addr;
    logic [DW-1:0] lkp_data, ram_wr_data, ram_rd_data;
    logic          ram_wr_en, busy, tbl_valid, load_done, load_err;

    always #5 clk = ~clk;

    lut_stream_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .lkp_addr(lkp_addr), .lkp_data(lkp_data), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_wr_en(ram_wr_en), .ram_rd_data(ram_rd_data), .busy(busy), .tbl_valid(tbl_valid),
        .load_done(load_done), .load_err(load_err)
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'hC000 + 16'(i);
    endfunction

    logic [15:0] mem [16];
    logic        inited = 1'b0;
    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            inited <= 1'b1;
        end else if (ram_wr_en) begin
            mem[ram_addr] <= ram_wr_data;
        end
        ram_rd_data <= mem[ram_addr];
    end

    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [3:0]  wr_a_q [$];
    logic [15:0] wr_d_q [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ram_wr_en === 1'b1) begin
            wr_a_q.push_back(ram_addr);
            wr_d_q.push_back(ram_wr_data);
        end
        if (load_done === 1'b1) done_cnt <= done_cnt + 1;
        if (load_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    typedef struct {
        logic rnd_words;
        logic bad_csum;
        int   noise;
        int   max_gap;
        int   csum_gap;
        logic exp_done;
        logic exp_err;
        logic exp_valid;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] ew [16];
    logic [15:0] ref_mem [16];
    logic        ref_valid;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_payload(input int k0, input int k1, input int max_gap);
        for (int k = k0; k < k1; k++) begin
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
            send_byte((k % 2 == 0) ? ew[k / 2][15:8] : ew[k / 2][7:0]);
        end
    endtask

    function automatic logic [7:0] table_sum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + ew[i][15:8] + ew[i][7:0];
        return s;
    endfunction

    task automatic check_writes(input int base, input int n, input string nm);
        check({nm, "_wr_count"}, wr_a_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wr_a_q.size()) begin
                check({nm, "_wr_addr"}, wr_a_q[base + i], i);
                check({nm, "_wr_data"}, wr_d_q[base + i], ew[i]);
            end
            ref_mem[i] = ew[i];
        end
    endtask

    task automatic lookup(input int a, input string nm);
        lkp_addr = 4'(a);
        @(posedge clk);
        #1;
        check(nm, lkp_data, ref_valid ? ref_mem[a] : 16'h0000);
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        logic [7:0] csum;
        logic [7:0] noise_b [3];
        int d0, e0, w0;
        noise_b[0] = 8'h00; noise_b[1] = 8'hFF; noise_b[2] = 8'h5A;
        for (int i = 0; i < 16; i++) ew[i] = v.rnd_words ? 16'($urandom) : 16'(i);
        csum = 8'h00 - table_sum() + (v.bad_csum ? 8'h01 : 8'h00);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_a_q.size();
        for (int i = 0; i < v.noise; i++) send_byte(noise_b[i % 3]);
        if (v.noise > 0) begin
            idle(1);
            check({nm, "_noise_busy"}, busy, 1'b0);
            check({nm, "_noise_writes"}, wr_a_q.size() - w0, 0);
        end
        send_byte(8'hA5);
        send_payload(0, 32, v.max_gap);
        idle(v.csum_gap);
        send_byte(csum);
        idle(3);
        check({nm, "_done"}, done_cnt - d0, v.exp_done);
        check({nm, "_err"}, err_cnt - e0, v.exp_err);
        check({nm, "_tbl_valid"}, tbl_valid, v.exp_valid);
        check({nm, "_busy"}, busy, 1'b0);
        check_writes(w0, 16, nm);
        ref_valid = !v.bad_csum;
        lookup(5, {nm, "_lkp5"});
        if (v.bad_csum) for (int a = 0; a < 16; a++) lookup(a, {nm, "_lkp_all"});
        else lookup($urandom_range(15, 0), {nm, "_lkp_rnd"});
    endtask

    initial begin
        int d0, e0, w0, acc, waited;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; lkp_addr = '0;
        vecs[0] = '{1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 3, 0, 0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 0, 5, 2, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 0, 3, 0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 0, TO - 1, TO - 1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        ref_valid = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tbl_valid", tbl_valid, 1'b1);
        check("rst_wr_en", ram_wr_en, 1'b0);
        check("rst_wr_data", ram_wr_data, 16'h0000);
        check("rst_pulses", {load_done, load_err}, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        check("s_ready_after_rst", s_ready, 1'b1);
        lookup(7, "init_lkp7");

        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Loader owns the RAM port mid-frame regardless of lkp_addr
        for (int i = 0; i < 16; i++) ew[i] = 16'h0200 + 16'(i);
        d0 = done_cnt; w0 = wr_a_q.size();
        send_byte(8'hA5);
        send_payload(0, 5, 0);
        idle(2);
        lkp_addr = 4'd3;
        @(negedge clk);
        check("pass_ram_addr", ram_addr, 4'(5 / 2));
        check("pass_busy", busy, 1'b1);
        @(negedge clk);
        check("pass_lkp_data", lkp_data, 16'h0000);
        #1;
        send_payload(5, 32, 0);
        send_byte(8'h00 - table_sum());
        idle(3);
        check("pass_done", done_cnt - d0, 1);
        check_writes(w0, 16, "pass");
        ref_valid = 1'b1;
        lookup(3, "pass_lkp3");

        // Timeout: 7 bytes then silence
        for (int i = 0; i < 16; i++) ew[i] = 16'h3300 + 16'(i);
        e0 = err_cnt; d0 = done_cnt; w0 = wr_a_q.size();
        send_byte(8'hA5);
        send_payload(0, 7, 0);
        acc = cyc;
        waited = 0;
        while (load_err !== 1'b1 && waited < 3 * TO) begin
            @(negedge clk);
            waited++;
        end
        check("tout_seen", load_err, 1'b1);
        check("tout_latency", cyc - acc, TO);
        idle(2);
        check("tout_err", err_cnt - e0, 1);
        check("tout_done", done_cnt - d0, 0);
        check("tout_busy", busy, 1'b0);
        check("tout_tbl_valid", tbl_valid, 1'b0);
        check_writes(w0, 3, "tout");
        ref_valid = 1'b0;
        lookup(1, "tout_lkp1");

        // Reset after 10 payload bytes
        for (int i = 0; i < 16; i++) ew[i] = 16'h1100 + 16'(i);
        e0 = err_cnt; w0 = wr_a_q.size();
        send_byte(8'hA5);
        send_payload(0, 10, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_s_ready", s_ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        check("midrst_s_ready_rel", s_ready, 1'b1);
        check("midrst_tbl_valid", tbl_valid, 1'b1);
        idle(2);
        check("midrst_no_err", err_cnt - e0, 0);
        check_writes(w0, 5, "midrst");
        ref_valid = 1'b1;
        lookup(2, "midrst_lkp2");
        run_frame(vecs[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
